// File: rtl/entrada_bcd.sv
// entrada_bcd: serial BCD operand entry with BCD-to-binary conversion.
// Digits arrive most significant first, and a sign toggle is accepted while
// the entry is open. The result is held on a pronto/aceito handshake.
// Optional feature macro: ENTRADA_BCD_SATURA_EN. When it is defined, an
// out-of-range confirma saturates valor instead of raising erro.
//
// state   | meaning
// VAZIO   | no digits entered, acc=0, ndig=0
// ENTRADA | at least one digit entered, entry still open
// PRONTO  | valor holds the converted operand until aceito
// ERRO    | invalid entry, only limpa or reset leaves
module entrada_bcd #(
    parameter int W    = 7,
    parameter int NDIG = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   digito,
    input  logic         dig_valido,
    input  logic         troca_sinal,
    input  logic         confirma,
    input  logic         limpa,
    input  logic         aceito,
    output logic [W-1:0] valor,
    output logic         pronto,
    output logic         erro,
    output logic [1:0]   ndig,
    output logic         sinal
);

    localparam int AW = $clog2(10 ** NDIG);
    localparam logic [31:0] POS_MAX = 32'((1 << (W - 1)) - 1);
    localparam logic [31:0] NEG_MAX = 32'(1 << (W - 1));

    typedef enum logic [1:0] {VAZIO, ENTRADA, PRONTO, ERRO} estado_t;

    estado_t       estado, estado_n;
    logic [AW-1:0] acc, acc_n;
    logic          sinal_r, sinal_n;
    logic [1:0]    ndig_r, ndig_n;
    logic [W-1:0]  valor_r, valor_n;

    logic [31:0]   acc32;
    logic [W-1:0]  mag_w;
    logic [W-1:0]  sat_val;
    logic          sinal_t;
    logic          fora_faixa;

    assign acc32   = 32'(acc);
    assign mag_w   = W'(acc);
    // The toggle is applied before the range check when it arrives with confirma.
    assign sinal_t = sinal_r ^ troca_sinal;
    assign fora_faixa = sinal_t ? (acc32 > NEG_MAX) : (acc32 > POS_MAX);
    assign sat_val = sinal_t ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

    // State and datapath registers; every output is taken from these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado  <= VAZIO;
            acc     <= '0;
            sinal_r <= 1'b0;
            ndig_r  <= 2'd0;
            valor_r <= '0;
        end else begin
            estado  <= estado_n;
            acc     <= acc_n;
            sinal_r <= sinal_n;
            ndig_r  <= ndig_n;
            valor_r <= valor_n;
        end
    end

    // Next-state and datapath update; priority limpa > aceito > confirma > digit.
    always_comb begin
        estado_n = estado;
        acc_n    = acc;
        sinal_n  = sinal_r;
        ndig_n   = ndig_r;
        valor_n  = valor_r;
        if (limpa) begin
            estado_n = VAZIO;
            acc_n    = '0;
            sinal_n  = 1'b0;
            ndig_n   = 2'd0;
            valor_n  = '0;
        end else begin
            case (estado)
                VAZIO, ENTRADA: begin
                    sinal_n = sinal_t;
                    // confirma in VAZIO does nothing, so a digit in the same cycle still counts.
                    if (confirma && estado == ENTRADA) begin
                        if (!fora_faixa) begin
                            estado_n = PRONTO;
                            valor_n  = sinal_t ? (~mag_w + 1'b1) : mag_w;
                        end else begin
`ifdef ENTRADA_BCD_SATURA_EN
                            estado_n = PRONTO;
                            valor_n  = sat_val;
`else
                            estado_n = ERRO;
                            valor_n  = '0;
`endif
                        end
                    end else if (dig_valido) begin
                        if (digito > 4'd9 || ndig_r == 2'(NDIG)) begin
                            estado_n = ERRO;
                            valor_n  = '0;
                        end else begin
                            estado_n = ENTRADA;
                            acc_n    = (acc << 3) + (acc << 1) + AW'(digito);
                            ndig_n   = ndig_r + 2'd1;
                        end
                    end
                end
                PRONTO: begin
                    if (aceito) begin
                        estado_n = VAZIO;
                        acc_n    = '0;
                        sinal_n  = 1'b0;
                        ndig_n   = 2'd0;
                        valor_n  = '0;
                    end
                end
                default: begin
                    valor_n = '0;
                end
            endcase
        end
    end

`ifndef ENTRADA_BCD_SATURA_EN
    logic unused_sat;
    assign unused_sat = ^sat_val;
`endif

    assign valor  = valor_r;
    assign pronto = (estado == PRONTO);
    assign erro   = (estado == ERRO);
    assign ndig   = ndig_r;
    assign sinal  = sinal_r;

endmodule

// File: tb/tb_entrada_bcd.sv
// Testbench for entrada_bcd: directed test-plan sequences, then random stimulus
// compared cycle by cycle against a digit-list reference model.
module tb_entrada_bcd;

    localparam int W    = 7;
    localparam int NDIG = 2;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   digito = '0;
    logic         dig_valido = 1'b0;
    logic         troca_sinal = 1'b0;
    logic         confirma = 1'b0;
    logic         limpa = 1'b0;
    logic         aceito = 1'b0;
    logic [W-1:0] valor;
    logic         pronto;
    logic         erro;
    logic [1:0]   ndig;
    logic         sinal;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 empty, 1 entering, 2 ready, 3 error.
    int m_st = 0;
    int m_dig[$];
    int m_sign = 0;
    int m_val = 0;

    entrada_bcd #(.W(W), .NDIG(NDIG)) dut (
        .clk(clk), .rst_n(rst_n), .digito(digito), .dig_valido(dig_valido),
        .troca_sinal(troca_sinal), .confirma(confirma), .limpa(limpa),
        .aceito(aceito), .valor(valor), .pronto(pronto), .erro(erro),
        .ndig(ndig), .sinal(sinal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_st = 0;
        m_dig.delete();
        m_sign = 0;
        m_val = 0;
    endfunction

    function automatic void model_step(int d, int dv, int ts, int cf, int lp, int ac);
        int v;
        int ns;
        if (lp != 0) begin
            model_clear();
        end else if (m_st == 0 || m_st == 1) begin
            ns = m_sign ^ ts;
            m_sign = ns;
            if (cf != 0 && m_st == 1) begin
                v = 0;
                foreach (m_dig[i]) v = v * 10 + m_dig[i];
                if ((ns == 0 && v <= (1 << (W - 1)) - 1) || (ns == 1 && v <= (1 << (W - 1)))) begin
                    m_st = 2;
                    m_val = (ns != 0) ? -v : v;
                end else begin
`ifdef ENTRADA_BCD_SATURA_EN
                    m_st = 2;
                    m_val = (ns != 0) ? -(1 << (W - 1)) : (1 << (W - 1)) - 1;
`else
                    m_st = 3;
                    m_val = 0;
`endif
                end
            end else if (dv != 0) begin
                if (d > 9 || m_dig.size() == NDIG) begin
                    m_st = 3;
                    m_val = 0;
                end else begin
                    m_dig.push_back(d);
                    m_st = 1;
                end
            end
        end else if (m_st == 2) begin
            if (ac != 0) model_clear();
        end
    endfunction

    task automatic check_all();
        chk("valor", int'(valor), m_val & MASK);
        chk("pronto", int'(pronto), (m_st == 2) ? 1 : 0);
        chk("erro", int'(erro), (m_st == 3) ? 1 : 0);
        chk("ndig", int'(ndig), m_dig.size());
        chk("sinal", int'(sinal), m_sign);
    endtask

    // Drives one cycle of inputs, clocks, updates the model and checks outputs.
    task automatic step(input int d, input int dv, input int ts, input int cf,
                        input int lp, input int ac);
        digito      = 4'(d);
        dig_valido  = (dv != 0);
        troca_sinal = (ts != 0);
        confirma    = (cf != 0);
        limpa       = (lp != 0);
        aceito      = (ac != 0);
        @(posedge clk);
        model_step(d, dv, ts, cf, lp, ac);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic dig(input int d);
        step(d, 1, 0, 0, 0, 0);
    endtask

    initial begin
        #12;
        chk("reset_valor", int'(valor), 0);
        chk("reset_pronto", int'(pronto), 0);
        chk("reset_ndig", int'(ndig), 0);
        rst_n = 1'b1;
        idle();

        // 42, hold, accept
        dig(4);
        dig(2);
        step(0, 0, 0, 1, 0, 0);
        chk("v42", int'(valor), 42);
        chk("v42_ndig", int'(ndig), 2);
        for (int i = 0; i < 5; i++) idle();
        chk("v42_hold", int'(valor), 42);
        step(0, 0, 0, 0, 0, 1);
        chk("v42_acc_pronto", int'(pronto), 0);
        chk("v42_acc_valor", int'(valor), 0);

        // -64 legal, +64 out of range
        step(0, 0, 1, 0, 0, 0);
        dig(6);
        dig(4);
        step(0, 0, 0, 1, 0, 0);
        chk("vm64", int'(valor), 64);
        chk("vm64_sinal", int'(sinal), 1);
        step(0, 0, 0, 0, 0, 1);
        dig(6);
        dig(4);
        step(0, 0, 0, 1, 0, 0);
`ifdef ENTRADA_BCD_SATURA_EN
        chk("v64_sat", int'(valor), 63);
        step(0, 0, 0, 0, 0, 1);
`else
        chk("v64_erro", int'(erro), 1);
        step(0, 0, 0, 0, 1, 0);
`endif

        // invalid digit, stuck in error until limpa
        dig(10);
        chk("bad_digit", int'(erro), 1);
        dig(3);
        step(0, 0, 0, 1, 0, 0);
        chk("erro_hold", int'(erro), 1);
        step(0, 0, 0, 0, 1, 0);
        chk("limpa_erro", int'(erro), 0);

        // too many digits, then confirma in VAZIO
        dig(1);
        dig(2);
        dig(3);
        chk("too_many", int'(erro), 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("conf_vazio", int'(pronto), 0);

        // same-cycle priorities
        dig(3);
        step(5, 1, 0, 1, 0, 0);
        chk("dig_conf", int'(valor), 3);
        step(0, 0, 0, 0, 0, 1);
        dig(7);
        step(0, 0, 1, 1, 0, 0);
        chk("ts_conf", int'(valor), 7'b1111001);
        step(0, 0, 0, 0, 0, 1);

        // asynchronous reset mid-entry
        dig(9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ndig", int'(ndig), 0);
        chk("async_rst_pronto", int'(pronto), 0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
        dig(8);
        step(0, 0, 0, 1, 0, 0);
        chk("after_rst", int'(valor), 8);
        step(0, 0, 0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int d, dv, ts, cf, lp, ac;
            d  = ($urandom_range(0, 15) < 14) ? $urandom_range(0, 9) : $urandom_range(10, 15);
            dv = ($urandom_range(0, 99) < 40) ? 1 : 0;
            ts = ($urandom_range(0, 99) < 10) ? 1 : 0;
            cf = ($urandom_range(0, 99) < 15) ? 1 : 0;
            lp = ($urandom_range(0, 99) < 4) ? 1 : 0;
            ac = ($urandom_range(0, 99) < 25) ? 1 : 0;
            step(d, dv, ts, cf, lp, ac);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/entrada_bcd.md
# entrada_bcd

Serial BCD operand entry and BCD-to-binary converter, the input-side counterpart of the calculator's binary-to-BCD display path. It accepts decimal digits one at a time, most significant digit first, plus a sign toggle. It then converts the entered number to a W-bit two's-complement operand and holds it on a valid/accept handshake until the consumer (operand register A or B of the calculator) takes it.

## Interface
Parameters:
- W, 7: output operand width, two's complement.
- NDIG, 2: maximum digits per entry (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- digito  in  4  BCD digit; sampled only when dig_valido=1.
- dig_valido  in  1  one-cycle digit strobe.
- troca_sinal  in  1  one-cycle strobe; toggles the sign of the entry in progress.
- confirma  in  1  one-cycle strobe; ends entry and requests conversion.
- limpa  in  1  synchronous clear; returns to VAZIO from any state.
- aceito  in  1  consumer accepts valor while pronto=1.
- valor  out  W  converted operand, two's complement.
- pronto  out  1  valor valid; held until aceito.
- erro  out  1  entry error; held until limpa.
- ndig  out  2  digits entered so far (0..NDIG).
- sinal  out  1  current sign flag (1 = negative), for the display.

## Operation
- Internal state: acc (unsigned, ceil(log2(10^NDIG)) bits), sign flag, digit count, FSM.
- FSM states:
  - VAZIO: acc=0, ndig=0.
  - ENTRADA: at least one digit entered.
  - PRONTO
  - ERRO
- Digit accept, in VAZIO or ENTRADA:
  - acc <= (acc<<3)+(acc<<1)+digito; ndig increments; state goes to ENTRADA.
  - digito>9 -> ERRO.
  - A digit arriving when ndig==NDIG -> ERRO.
- troca_sinal in VAZIO or ENTRADA toggles the sign flag. It is ignored in PRONTO and ERRO.
- confirma:
  - Ignored in VAZIO.
  - In ENTRADA: range check, then either PRONTO or ERRO.
  - Positive entries are legal up to 2^(W-1)-1 (63 for W=7).
  - Negative entries are legal down to magnitude 2^(W-1) (64).
  - Negative zero converts to 0.
- PRONTO:
  - valor = sign ? -acc : acc; pronto=1.
  - dig_valido, troca_sinal and confirma are ignored.
  - aceito -> VAZIO, with sign, acc and ndig cleared.
- ERRO: erro=1, valor=0, pronto=0. Only limpa or reset exits.
- Same-cycle priority: limpa > aceito > confirma > dig_valido.
  - confirma together with dig_valido: the digit is dropped and the conversion uses the digits entered before it.
  - troca_sinal together with dig_valido: both are applied.
  - troca_sinal together with confirma: the toggle applies before the range check.
- limpa from any state clears acc, sign and ndig and goes to VAZIO.
- valor is 0 in every state except PRONTO.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=VAZIO
  - valor=0, pronto=0, erro=0, ndig=0, sinal=0.
- Reset mid-entry or mid-handshake discards everything; no output pulse results.
- All outputs are registered.
- A digit strobe in cycle N updates ndig in cycle N+1.
- confirma in cycle N gives pronto=1 (or erro=1) in cycle N+1, with valor stable that same cycle.
- pronto stays high with valor constant for any number of cycles until aceito.
  - aceito in cycle M: pronto=0 and valor=0 in cycle M+1.
  - aceito while pronto=0 is ignored.
- A new digit is accepted no earlier than the cycle after returning to VAZIO.

## Configuration
- ENTRADA_BCD_SATURA_EN defined:
  - An out-of-range confirma goes to PRONTO instead of ERRO.
  - valor saturates to 2^(W-1)-1 (positive) or -2^(W-1) (negative).
  - pronto asserts normally; erro is not asserted.
  - Invalid digits and too many digits still go to ERRO.
- Not defined: an out-of-range confirma goes to ERRO as described in Operation.

## Test plan
- Digits 4, 2, then confirma -> next cycle pronto=1, valor=7'b0101010 (42), ndig=2. Hold aceito low for 5 cycles -> valor unchanged. Pulse aceito -> next cycle pronto=0, valor=0, ndig=0.
- troca_sinal, digits 6, 4, confirma -> valor=7'b1000000 (-64), sinal=1. Digits 6, 4 positive, confirma -> erro=1 (without the macro), or pronto=1 with valor=7'b0111111 (with ENTRADA_BCD_SATURA_EN).
- Digit 4'hA -> erro=1 next cycle. Further digits and confirma -> no change. limpa -> VAZIO, erro=0.
- Digits 1, 2, 3 (NDIG=2) -> erro=1 after the third strobe. confirma in VAZIO -> no pronto.
- Digit 5 together with confirma after digit 3 -> valor=3. troca_sinal with confirma after digit 7 -> valor=-7 (7'b1111001).
- Digit 9, then rst_n low for 1 cycle mid-entry -> all outputs 0 immediately. Then digit 8, confirma -> valor=8.
